// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared state encoding, default widths and phase-counter sizing for sram_ctrl
package sram_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, STROBE = 2'd2, HOLD = 2'd3} state_e;
  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 8;
  function automatic int cnt_w(input int s, input int p, input int h);
    int m;
    m = (s > p) ? s : p;
    m = (m > h) ? m : h;
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/sram_phase_timer.sv
// sram_phase_timer: loadable down-counter; done_o marks the last cycle of a timed phase
//   clk, rst : clock, synchronous active-high reset
//   load_i   : reload with val_i (asserted on every state entry)
//   val_i    : phase length in cycles
//   done_o   : current cycle is the final one of the phase
module sram_phase_timer #(parameter int W = 2) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         done_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else if (load_i) cnt_q <= val_i;
    else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  assign done_o = cnt_q <= W'(1);
endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: synchronous initiator sequencing setup/strobe/hold accesses to an asynchronous SRAM
//   clk, rst                          : clock, synchronous active-high reset
//   req_valid/ready/write/addr/wdata  : single-access request handshake
//   rsp_valid, rsp_rdata              : one-cycle read response pulse and captured data
//   sram_addr, sram_re, sram_we       : registered SRAM control pins
//   sram_data                         : shared bus, driven only for writes
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_re,
  output logic              sram_we,
  inout  wire  [DATA_W-1:0] sram_data
);
  localparam int CW = cnt_w(SETUP_CYC, PULSE_CYC, HOLD_CYC);
  state_e state_q, state_d;
  logic accept, done, wr_q, wr_d, re_q, we_q, drv_q, rsp_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [CW-1:0] load_val;
  assign req_ready = state_q == IDLE;
  assign accept    = req_valid && req_ready;
  // States are encoded in access order, so a finished timed phase simply steps to the next code.
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) state_d = accept ? SETUP : IDLE;
    else if (done) state_d = (state_q == HOLD) ? IDLE : state_e'(state_q + 2'd1);
    wr_d     = accept ? req_write : wr_q;
    load_val = (state_d == SETUP) ? CW'(SETUP_CYC) : (state_d == STROBE) ? CW'(PULSE_CYC) : CW'(HOLD_CYC);
  end
  sram_phase_timer #(.W(CW)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (state_d != state_q),
    .val_i  (load_val),
    .done_o (done)
  );
  // Pin registers are loaded from the next state so each pin changes exactly with the state.
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      drv_q   <= 1'b0;
      rsp_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      re_q  <= state_d == STROBE && !wr_d;
      we_q  <= state_d == STROBE && wr_d;
      drv_q <= state_d != IDLE && wr_d;
      rsp_q <= state_q == HOLD && done && !wr_q;
      if (state_q == STROBE && done && !wr_q) rdata_q <= sram_data;
    end
  assign rsp_valid = rsp_q;
  assign rsp_rdata = rdata_q;
  assign sram_addr = addr_q;
  assign sram_re   = re_q;
  assign sram_we   = we_q;
  assign sram_data = drv_q ? wdata_q : {DATA_W{1'bz}};
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: table-driven, hand-sequenced and random checks of sram_ctrl against SRAM models
module tb_sram_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic va = 1'b0, vb = 1'b0, rw = 1'b0;
  logic [12:0] ra = '0;
  logic [7:0] rd = '0;
  logic rdy_a, rv_a, re_a, we_a, rdy_b, rv_b, re_b, we_b;
  logic [7:0] rdat_a, rdat_b;
  logic [12:0] sa_a, sa_b;
  wire [7:0] sd_a, sd_b;
  logic [7:0] mem_a [8192];
  logic [7:0] mem_b [8192];
  logic [7:0] refm_a [8192];
  logic [7:0] refm_b [8192];
  int cmp = 0, err = 0, inv_err = 0;
  logic pst_a = 1'b0, pst_b = 1'b0;
  logic [12:0] psa_a = '0, psa_b = '0;

  always #5 clk = ~clk;

  sram_ctrl dut_a (
    .clk(clk), .rst(rst), .req_valid(va), .req_ready(rdy_a), .req_write(rw), .req_addr(ra),
    .req_wdata(rd), .rsp_valid(rv_a), .rsp_rdata(rdat_a), .sram_addr(sa_a), .sram_re(re_a),
    .sram_we(we_a), .sram_data(sd_a));
  sram_ctrl #(.SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(2)) dut_b (
    .clk(clk), .rst(rst), .req_valid(vb), .req_ready(rdy_b), .req_write(rw), .req_addr(ra),
    .req_wdata(rd), .rsp_valid(rv_b), .rsp_rdata(rdat_b), .sram_addr(sa_b), .sram_re(re_b),
    .sram_we(we_b), .sram_data(sd_b));

  // Asynchronous SRAM models: drive the bus while re is high, store while we is high.
  assign sd_a = re_a ? mem_a[sa_a] : 8'bz;
  assign sd_b = re_b ? mem_b[sa_b] : 8'bz;
  always @(posedge clk) if (we_a) mem_a[sa_a] <= sd_a;
  always @(posedge clk) if (we_b) mem_b[sa_b] <= sd_b;

  always @(negedge clk) begin
    if (!rst) begin
      if ((re_a && we_a) || (re_b && we_b)) begin
        inv_err++;
        $display("invariant: re and we both high at %0t", $time);
      end
      if ((pst_a && (re_a || we_a) && sa_a != psa_a) || (pst_b && (re_b || we_b) && sa_b != psa_b)) begin
        inv_err++;
        $display("invariant: address moved during strobe at %0t", $time);
      end
    end
    pst_a = re_a || we_a;
    pst_b = re_b || we_b;
    psa_a = sa_a;
    psa_b = sa_b;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string n, input int act, input int exp);
    cmp++;
    if (act != exp) begin
      err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", n, act, act, exp, exp);
    end
  endtask

  // One isolated access; request inputs are scrambled right after the accept edge.
  task automatic access(input bit sel, input bit wr, input logic [12:0] a, input logic [7:0] d,
                        input logic [7:0] exp, input string n);
    int s, p, h, tot, strb, first, busy, rvn, rvat, bus_err;
    logic [7:0] got;
    bit ok;
    s = sel ? 3 : 1;
    p = sel ? 1 : 2;
    h = sel ? 2 : 1;
    tot = s + p + h;
    strb = 0; first = 0; busy = 0; rvn = 0; rvat = 0; bus_err = 0; got = '0; ok = 0;
    @(negedge clk);
    rw = wr; ra = a; rd = d;
    if (sel) vb = 1'b1; else va = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (sel ? rdy_b : rdy_a) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      check({n, " accept timeout"}, 0, 1);
      va = 1'b0; vb = 1'b0;
      return;
    end
    @(posedge clk);
    #1 va = 1'b0; vb = 1'b0; rw = ~wr; ra = ~a; rd = ~d;
    for (int c = 1; c <= tot + 2; c++) begin
      @(negedge clk);
      if (sel ? (re_b || we_b) : (re_a || we_a)) begin
        strb++;
        if (first == 0) first = c;
      end
      if (!(sel ? rdy_b : rdy_a)) begin
        busy++;
        if (wr && (sel ? sd_b : sd_a) != d) bus_err++;
      end
      if (sel ? rv_b : rv_a) begin
        rvn++;
        rvat = c;
        got = sel ? rdat_b : rdat_a;
      end
    end
    check({n, " strobe width"}, strb, p);
    check({n, " first strobe cycle"}, first, s + 1);
    check({n, " busy cycles"}, busy, tot);
    check({n, " rsp pulses"}, rvn, wr ? 0 : 1);
    if (wr) begin
      check({n, " write bus value"}, bus_err, 0);
      if (sel) refm_b[a] = d; else refm_a[a] = d;
    end else begin
      check({n, " rsp cycle"}, rvat, tot + 1);
      check({n, " rdata"}, int'(got), int'(exp));
    end
  endtask

  typedef struct {
    bit sel;
    bit wr;
    logic [12:0] a;
    logic [7:0] d;
    logic [7:0] exp;
    string n;
  } vec_t;
  vec_t vecs [11];

  initial begin
    int acc, rvat;
    logic [7:0] got;
    bit seen;
    for (int i = 0; i < 8192; i++) begin
      mem_a[i] = '0; mem_b[i] = '0; refm_a[i] = '0; refm_b[i] = '0;
    end
    vecs[0]  = '{0, 1, 13'h0001, 8'hAA, 8'h00, "wr1"};
    vecs[1]  = '{0, 0, 13'h0001, 8'h00, 8'hAA, "rd1"};
    vecs[2]  = '{0, 1, 13'h0002, 8'hCC, 8'h00, "wr2"};
    vecs[3]  = '{0, 0, 13'h0002, 8'h00, 8'hCC, "rd2"};
    vecs[4]  = '{0, 1, 13'h1FFE, 8'h11, 8'h00, "wr1ffe"};
    vecs[5]  = '{0, 1, 13'h1FFF, 8'hFC, 8'h00, "wr1fff"};
    vecs[6]  = '{0, 0, 13'h1FFF, 8'h00, 8'hFC, "rd1fff"};
    vecs[7]  = '{0, 0, 13'h1FFE, 8'h00, 8'h11, "rd1ffe"};
    vecs[8]  = '{1, 1, 13'h0010, 8'h5A, 8'h00, "b_wr"};
    vecs[9]  = '{1, 0, 13'h0010, 8'h00, 8'h5A, "b_rd"};
    vecs[10] = '{1, 0, 13'h1FFF, 8'h00, 8'h00, "b_rd_top"};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset ready", rdy_a, 1);
    check("reset rsp_valid", rv_a, 0);
    check("reset rdata", rdat_a, 0);
    check("reset addr", sa_a, 0);
    check("reset re/we", {re_a, we_a}, 0);
    check("reset ready b", rdy_b, 1);

    foreach (vecs[i]) access(vecs[i].sel, vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].exp, vecs[i].n);

    // Back-to-back: write then read with req_valid held; second accept on first IDLE cycle.
    @(negedge clk);
    rw = 1'b1; ra = 13'h0004; rd = 8'h55; va = 1'b1;
    @(posedge clk);
    #1 rw = 1'b0; rd = 8'h00;
    acc = 0; rvat = 0; got = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (rdy_a) begin acc = c; break; end
    end
    check("b2b second accept cycle", acc, 5);
    @(posedge clk);
    #1 va = 1'b0;
    @(negedge clk);
    check("b2b busy after accept", rdy_a, 0);
    for (int c = acc + 2; c <= acc + 20; c++) begin
      @(negedge clk);
      if (rv_a) begin rvat = c; got = rdat_a; break; end
    end
    check("b2b rsp cycle", rvat, 10);
    check("b2b rdata", got, 8'h55);
    refm_a[4] = 8'h55;

    // Reset while a write strobe is high.
    @(negedge clk);
    rw = 1'b1; ra = 13'h0008; rd = 8'h77; va = 1'b1;
    @(posedge clk);
    #1 va = 1'b0;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (we_a) begin seen = 1; break; end
    end
    check("abort saw strobe", seen, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort we", we_a, 0);
    check("abort re", re_a, 0);
    check("abort ready", rdy_a, 1);
    check("abort rsp_valid", rv_a, 0);
    @(negedge clk);
    rst = 1'b0;
    access(0, 1, 13'h0008, 8'h3C, 8'h00, "post_abort_wr");
    access(0, 0, 13'h0008, 8'h00, 8'h3C, "post_abort_rd");

    // Random accesses checked against the array reference.
    for (int i = 0; i < 30; i++) begin
      bit wr;
      logic [12:0] a;
      logic [7:0] d;
      wr = 1'($urandom);
      a = 13'($urandom_range(0, 15)) | (($urandom % 2) != 0 ? 13'h1FF0 : 13'h0000);
      d = 8'($urandom);
      access(0, wr, a, d, refm_a[a], "rand");
    end

    check("invariants", inv_err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
